// File: rtl/sevenseg_scan.sv
// Six-digit multiplexed seven-segment driver for a HH:MM:SS clock.
// Scans one digit per SCAN_DIV cycles, with a blanking guard at the start of every slot.
module sevenseg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    input  logic       sec_tick,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic [23:0]   snap_q, snap_d;
    logic          colon_q, colon_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          show;
    logic [3:0]    cur_digit;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h3F;
        endcase
    endfunction

    always_comb begin
        cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        slot_d = slot_q;
        if (cnt_q == CNT_MAX) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end
        // Frame-start snapshot keeps a whole scan frame consistent.
        snap_d    = (slot_q == 3'd0 && cnt_q == '0) ? {h2, h1, m2, m1, s2, s1} : snap_q;
        colon_d   = colon_q ^ sec_tick;
        show      = (cnt_q >= GUARD_C);
        cur_digit = snap_q[{slot_q, 2'b00} +: 4];
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        if (show) begin
            seg_d = enc(cur_digit);
            if (BLANK_LZ != 0 && slot_q == 3'd5 && cur_digit == 4'd0) begin
                seg_d = 7'h7F;
            end
            dp_d = ~(colon_q && (slot_q == 3'd2 || slot_q == 3'd4));
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_an
        assign an_d[gi] = ~(show && slot_q == 3'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            slot_q  <= 3'd0;
            snap_q  <= 24'd0;
            colon_q <= 1'b0;
            an_q    <= 6'h3F;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            colon_q <= colon_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: constant vectors, corner sequences and random traffic
// compared against a cycle-index based model of the scan.
module tb_sevenseg_scan;
    localparam int D = 8;
    localparam int G = 2;
    localparam int F = 6 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s1 = '0, s2 = '0, m1 = '0, m2 = '0, h1 = '0, h2 = '0;
    logic       sec_tick = 1'b0;
    logic [5:0] an, an0;
    logic [6:0] seg, seg0;
    logic       dp, dp0;

    always #5 clk = ~clk;

    sevenseg_scan #(.SCAN_DIV(D), .GUARD(G), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .sec_tick(sec_tick), .an(an), .seg(seg), .dp(dp)
    );
    sevenseg_scan #(.SCAN_DIV(D), .GUARD(G), .BLANK_LZ(0)) u_dut_nolz (
        .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
        .sec_tick(sec_tick), .an(an0), .seg(seg0), .dp(dp0)
    );

    int total = 0;
    int bad = 0;
    int n = 0;
    logic [3:0] snap_m [6];
    bit colon_m = 1'b0;
    logic [6:0] enc_tbl [16];

    typedef struct {
        logic [23:0] digits;
        int          slot;
        logic [5:0]  an;
        logic [6:0]  seg;
        logic [6:0]  seg_nolz;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_digits(input logic [23:0] d);
        {h2, h1, m2, m1, s2, s1} = d;
    endtask

    // One clock: predict the outputs from the model state, advance the model, compare.
    task automatic cycle();
        logic [5:0] e_an;
        logic [6:0] e_seg, e_seg0;
        logic       e_dp;
        int cnt, slot;
        cnt  = n % D;
        slot = (n / D) % 6;
        if (cnt < G) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an   = 6'h3F & ~(6'd1 << slot);
            e_seg  = enc_tbl[snap_m[slot]];
            e_seg0 = e_seg;
            if (slot == 5 && snap_m[5] == 4'd0) e_seg = 7'h7F;
            e_dp = !(colon_m && (slot == 2 || slot == 4));
        end
        if (n % F == 0) begin
            snap_m[0] = s1; snap_m[1] = s2; snap_m[2] = m1;
            snap_m[3] = m2; snap_m[4] = h1; snap_m[5] = h2;
        end
        if (sec_tick) colon_m = !colon_m;
        n++;
        @(posedge clk);
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("an_nolz", 32'(an0), 32'(e_an));
        check("seg_nolz", 32'(seg0), 32'(e_seg0));
        check("dp_nolz", 32'(dp0), 32'(e_dp));
    endtask

    // Advance until the visible outputs are those of frame position target (slot*D+cnt).
    task automatic to_out(input int target);
        int k;
        k = 0;
        while (((n - 1) % F) != target && k < 2 * F) begin
            cycle();
            k++;
        end
        if (k >= 2 * F) check("to_out_timeout", 32'(k), 32'(0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        colon_m = 1'b0;
        for (int i = 0; i < 6; i++) snap_m[i] = 4'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sec_tick = 1'b0;
        @(negedge clk);
        check("rst_an", 32'(an), 32'h3F);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        @(negedge clk);
        release_reset();
    endtask

    initial begin
        enc_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 6; i++) snap_m[i] = 4'd0;
        vecs[0] = '{24'h123050, 0, 6'h3E, 7'h40, 7'h40};
        vecs[1] = '{24'h123050, 1, 6'h3D, 7'h12, 7'h12};
        vecs[2] = '{24'h123050, 5, 6'h1F, 7'h79, 7'h79};
        vecs[3] = '{24'h093050, 5, 6'h1F, 7'h7F, 7'h40};
        vecs[4] = '{24'h093050, 4, 6'h2F, 7'h10, 7'h10};
        vecs[5] = '{24'h12C050, 3, 6'h37, 7'h3F, 7'h3F};
        vecs[6] = '{24'h12C050, 2, 6'h3B, 7'h40, 7'h40};
        vecs[7] = '{24'h876543, 0, 6'h3E, 7'h30, 7'h30};

        for (int i = 0; i < 8; i++) begin
            set_digits(vecs[i].digits);
            do_reset();
            cycle();
            check("guard_an", 32'(an), 32'h3F);
            to_out(vecs[i].slot * D + G);
            check("vec_an", 32'(an), 32'(vecs[i].an));
            check("vec_seg", 32'(seg), 32'(vecs[i].seg));
            check("vec_seg_nolz", 32'(seg0), 32'(vecs[i].seg_nolz));
            $display("vec %0d digits=%06h slot=%0d an=%02h seg=%02h seg_nolz=%02h",
                     i, vecs[i].digits, vecs[i].slot, an, seg, seg0);
        end

        // Input change mid-frame must not tear the current frame.
        set_digits(24'h123050);
        do_reset();
        to_out(3 * D + 3);
        s1 = 4'd7;
        to_out(5 * D + G);
        check("notear_slot5", 32'(seg), 32'h79);
        to_out(0 * D + G);
        check("nextframe_s1", 32'(seg), 32'h78);
        $display("seq notear: next frame slot0 seg=%02h", seg);

        // Colon: one tick lights slots 2 and 4, a second tick clears it.
        do_reset();
        sec_tick = 1'b1;
        cycle();
        sec_tick = 1'b0;
        to_out(2 * D + 1);
        check("colon_guard", 32'(dp), 32'h1);
        to_out(2 * D + G);
        check("colon_s2", 32'(dp), 32'h0);
        to_out(3 * D + G);
        check("colon_s3", 32'(dp), 32'h1);
        to_out(4 * D + G + 1);
        check("colon_s4", 32'(dp), 32'h0);
        sec_tick = 1'b1;
        cycle();
        sec_tick = 1'b0;
        to_out(2 * D + G);
        check("colon_off_s2", 32'(dp), 32'h1);
        to_out(4 * D + G);
        check("colon_off_s4", 32'(dp), 32'h1);
        $display("seq colon: dp after second tick=%0b", dp);

        // Asynchronous reset in the middle of slot 4.
        set_digits(24'h123050);
        do_reset();
        sec_tick = 1'b1;
        cycle();
        sec_tick = 1'b0;
        to_out(4 * D + 4);
        check("pre_rst_an", 32'(an), 32'h2F);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'h3F);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        release_reset();
        to_out(0 * D + G);
        check("resume_an", 32'(an), 32'h3E);
        to_out(2 * D + G);
        check("resume_dp", 32'(dp), 32'h1);
        $display("seq async reset: resumed an=%02h dp=%0b", an, dp);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) set_digits(24'($urandom));
            sec_tick = ($urandom_range(0, 6) == 0);
            cycle();
        end
        sec_tick = 1'b0;
        $display("random: 3000 cycles done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot; legal range 4..2^24.
REQ-002 SHALL have parameter GUARD, default 2, blanking cycles at start of each slot; legal range 1..SCAN_DIV-1.
REQ-003 SHALL have parameter BLANK_LZ, default 1, 1 = blank leading hour-tens zero.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports s1, s2, m1, m2, h1, h2  input  4 each  BCD time digits from the digital-clock counter (s1 = seconds units ... h2 = hours tens).
REQ-007 SHALL have port sec_tick  input  1  one-cycle pulse once per second.
REQ-008 SHALL have port an  output  6  digit enables, active-low; an[0] = s1 ... an[5] = h2.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point / colon, active-low.

Function
REQ-011 SHALL hold prescaler cnt that counts 0..SCAN_DIV-1 and wraps to 0; slot (0..5) SHALL advance by 1 on the cycle where cnt = SCAN_DIV-1, wrapping 5 -> 0.
REQ-012 SHALL capture all six digits into a 24-bit snapshot on every cycle with slot = 0 and cnt = 0, including the first cycle after reset release; between captures, input changes SHALL NOT affect the display (no tearing within a frame).
REQ-013 SHALL register an, seg and dp; each SHALL reflect the slot, cnt, snapshot and colon state of the previous cycle (1-cycle latency).
REQ-014 SHALL drive an = 6'h3F, seg = 7'h7F and dp = 1 while cnt < GUARD (anti-ghosting guard).
REQ-015 SHALL drive, while cnt >= GUARD, an with only bit [slot] low and seg = encoding of snapshot digit [slot].
REQ-016 SHALL use encodings 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex), blank=7F.
REQ-017 SHALL display dash (seg = 3F) for any digit value 10..15.
REQ-018 SHALL, when BLANK_LZ = 1 and snapshot h2 = 0, drive seg = 7F in slot 5, with an[5] still asserted.
REQ-019 SHALL toggle colon_on on each cycle where sec_tick = 1; sec_tick pulses longer than one cycle SHALL toggle once per high cycle.
REQ-020 SHALL drive dp = 0 only in slots 2 (m1) and 4 (h1), outside the guard, while colon_on = 1; otherwise dp = 1.
REQ-021 SHALL never assert more than one an bit in any cycle.

Reset
REQ-022 SHALL, on rst_n low, immediately and asynchronously force cnt = 0, slot = 0, snapshot = 0, colon_on = 0, an = 6'h3F, seg = 7'h7F and dp = 1, including mid-slot and mid-frame.
REQ-023 SHALL restart scanning at slot 0 after rst_n deasserts, with cnt = 0 on the first clock edge.

Verification (SCAN_DIV = 8, GUARD = 2, BLANK_LZ = 1 unless stated)
REQ-024 Reset release with digits 12:30:50 -> an = 3F for cycles 0..1; then an = 3E and seg = 40 (s1 = 0); slot 1 gives an = 3D and seg = 12; slot 5 gives an = 1F and seg = 79.
REQ-025 Change s1 from 0 to 7 during slot 3 -> slots 3..5 are unchanged; the next frame's slot 0 shows seg = 78.
REQ-026 h2 = 0, h1 = 9 -> slot 5 gives an = 1F and seg = 7F; the same stimulus with BLANK_LZ = 0 gives seg = 40.
REQ-027 m2 = 4'hC -> slot 3 shows seg = 3F; the other digits are unaffected.
REQ-028 A single sec_tick pulse -> dp = 0 during slots 2 and 4 only, outside the guard; a second pulse -> dp = 1 throughout.
REQ-029 Assert rst_n low at cnt = 5 of slot 4 -> outputs go blank without waiting for a clock edge; after release the scan resumes at slot 0 and colon_on = 0.
